// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared state type and mode helpers for the SPI register bank
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_e;

    // The R/W flag sits directly above the address field of the command word
    function automatic int rw_bit_pos(input int addr_width);
        return addr_width;
    endfunction

    // mode = {cpol, cpha}; modes 0 and 3 sample on the rising spi_clk edge
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return mode[1] == mode[0];
    endfunction

endpackage

// File: rtl/spi_regbank_burst_if.sv
// rtl/spi_regbank_burst_if.sv - synchronised SPI pins plus mode select
interface spi_regbank_burst_if;
    logic [1:0] mode;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (output mode, output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
    modport slave  (input mode, input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_regbank_burst_edge_det.sv
// rtl/spi_regbank_burst_edge_det.sv - spi_clk edge detector producing sample/shift strobes
module spi_edge_det
    import spi_regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic       spi_clk,
    input  logic [1:0] mode,
    output logic       sample_stb,
    output logic       shift_stb
);

    logic spi_clk_q, spi_clk_d;
    logic rise, fall;

    // The delayed copy always follows the pin so a re-enable never sees a stale edge
    always_comb begin
        spi_clk_d  = spi_clk;
        rise       = spi_clk & ~spi_clk_q;
        fall       = ~spi_clk & spi_clk_q;
        sample_stb = sample_on_rise(mode) ? rise : fall;
        shift_stb  = sample_on_rise(mode) ? fall : rise;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            spi_clk_q <= 1'b0;
        end else begin
            spi_clk_q <= spi_clk_d;
        end
    end

endmodule

// File: rtl/spi_regbank_burst.sv
// rtl/spi_regbank_burst.sv - burst SPI slave with packed config/status register banks
module spi_regbank_burst
    import spi_regbank_pkg::*;
#(
    parameter int                   NUM_CFG    = 4,
    parameter int                   NUM_STATUS = 4,
    parameter int                   REG_WIDTH  = 8,
    parameter int                   ADDR_WIDTH = 7,
    parameter logic [REG_WIDTH-1:0] CFG_RESET  = '0
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,
    spi_regbank_burst_if.slave               spi,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    output logic [NUM_CFG-1:0]               cfg_wr_stb,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic                             xfer_active
);

    localparam int RW_BIT   = rw_bit_pos(ADDR_WIDTH);
    localparam int CMD_BITS = ADDR_WIDTH + 1;
    localparam int RX_W     = (CMD_BITS > REG_WIDTH) ? CMD_BITS : REG_WIDTH;
    localparam int CNT_W    = $clog2(RX_W + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CFG + NUM_STATUS - 1);

    state_e                       state_q, state_d;
    logic [1:0]                   mode_q, mode_d;
    logic                         cs_n_q, cs_n_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [RX_W-1:0]              rx_q, rx_d;
    logic [REG_WIDTH-1:0]         tx_q, tx_d;
    logic                         wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic                         load_q, load_d;
    logic                         miso_q, miso_d;
    logic [NUM_CFG*REG_WIDTH-1:0] cfg_q, cfg_d;
    logic [NUM_CFG-1:0]           stb_q, stb_d;
    logic                         sample_stb, shift_stb;
    logic [REG_WIDTH-1:0]         rd_word, ld_word;

    spi_edge_det u_edge_det (
        .clk        (clk),
        .rstb       (rstb),
        .spi_clk    (spi.spi_clk),
        .mode       (mode_q),
        .sample_stb (sample_stb),
        .shift_stb  (shift_stb)
    );

    // Unmapped addresses read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) rd_word = cfg_q[i*REG_WIDTH +: REG_WIDTH];
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (addr_q == ADDR_WIDTH'(NUM_CFG + j)) rd_word = status_regs[j*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cs_n_d    = spi.spi_cs_n;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        load_d    = load_q;
        miso_d    = miso_q;
        cfg_d     = cfg_q;
        stb_d     = '0;
        ld_word   = wr_q ? '0 : rd_word;
        if (ena) begin
            // Chip-select release beats any edge arriving on the same cycle
            if (spi.spi_cs_n) begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_n_q) begin
                            state_d   = CMD;
                            mode_d    = spi.mode;
                            bit_cnt_d = '0;
                            load_d    = 1'b0;
                            miso_d    = 1'b0;
                        end
                    end
                    CMD: begin
                        if (sample_stb) begin
                            rx_d      = {rx_q[RX_W-2:0], spi.spi_mosi};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                                state_d   = DATA;
                                wr_d      = rx_d[RW_BIT];
                                addr_d    = rx_d[ADDR_WIDTH-1:0];
                                bit_cnt_d = '0;
                                load_d    = 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sample_stb) begin
                            rx_d      = {rx_q[RX_W-2:0], spi.spi_mosi};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(REG_WIDTH - 1)) begin
                                bit_cnt_d = '0;
                                load_d    = 1'b1;
                                addr_d    = (addr_q >= LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
                                for (int i = 0; i < NUM_CFG; i++) begin
                                    if (wr_q && addr_q == ADDR_WIDTH'(i)) begin
                                        cfg_d[i*REG_WIDTH +: REG_WIDTH] = rx_d[REG_WIDTH-1:0];
                                        stb_d[i] = 1'b1;
                                    end
                                end
                            end
                        end else if (shift_stb) begin
                            // First shift edge after a completed word snapshots the next read word
                            load_d = 1'b0;
                            miso_d = load_q ? ld_word[REG_WIDTH-1] : tx_q[REG_WIDTH-1];
                            tx_d   = load_q ? (ld_word << 1) : (tx_q << 1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            cs_n_q    <= 1'b1;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            miso_q    <= 1'b0;
            cfg_q     <= {NUM_CFG{CFG_RESET}};
            stb_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cs_n_q    <= cs_n_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            load_q    <= load_d;
            miso_q    <= miso_d;
            cfg_q     <= cfg_d;
            stb_q     <= stb_d;
        end
    end

    assign config_regs  = cfg_q;
    assign cfg_wr_stb   = stb_q;
    assign spi.spi_miso = miso_q;
    assign xfer_active  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_regbank_burst.sv
// tb/tb_spi_regbank_burst.sv - self-checking bench for spi_regbank_burst with a transaction-level model
module tb_spi_regbank_burst;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [31:0] config_regs;
    logic [3:0]  cfg_wr_stb;
    logic [31:0] status_regs;
    logic        xfer_active;

    spi_regbank_burst_if sif ();

    spi_regbank_burst dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .spi         (sif),
        .config_regs (config_regs),
        .cfg_wr_stb  (cfg_wr_stb),
        .status_regs (status_regs),
        .xfer_active (xfer_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] cfg_m    [4];
    logic [7:0] status_m [4];
    logic [7:0] wdata    [16];
    logic [7:0] rdata    [17];
    logic [7:0] exp_rd   [17];
    logic [3:0] stb_log  [$];
    logic [3:0] exp_stb  [$];

    always @(negedge clk) begin
        if (cfg_wr_stb != 4'b0) stb_log.push_back(cfg_wr_stb);
    end

    function automatic logic [31:0] cfg_flat();
        return {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]};
    endfunction

    task automatic set_status();
        status_regs = {status_m[3], status_m[2], status_m[1], status_m[0]};
    endtask

    // Bit-level SPI master; nbits=0 runs the whole transaction
    task automatic spi_xfer(input logic [1:0] md, input logic [7:0] cmd, input int nwords,
                            input int nbits, input bit keep_cs);
        int   total;
        int   w;
        int   bi;
        logic mo;
        total = 8 * (nwords + 1);
        if (nbits > 0 && nbits < total) total = nbits;
        for (int k = 0; k < 17; k++) rdata[k] = 8'h00;
        stb_log.delete();
        sif.mode     = md;
        sif.spi_clk  = md[1];
        sif.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        sif.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < total; b++) begin
            w  = b / 8;
            bi = 7 - (b % 8);
            if (w == 0) mo = cmd[bi];
            else        mo = wdata[w-1][bi];
            if (md[0] == 1'b0) begin
                sif.spi_mosi = mo;
                repeat (HALF) @(negedge clk);
                rdata[w][bi] = sif.spi_miso;
                sif.spi_clk  = ~md[1];
                repeat (HALF) @(negedge clk);
                sif.spi_clk  = md[1];
            end else begin
                sif.spi_clk  = ~md[1];
                sif.spi_mosi = mo;
                repeat (HALF) @(negedge clk);
                rdata[w][bi] = sif.spi_miso;
                sif.spi_clk  = md[1];
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        if (!keep_cs) begin
            sif.spi_cs_n = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    // Transaction-level model: what a master should read back and which strobes should fire
    task automatic model_xfer(input logic [7:0] cmd, input int ncomp);
        int a;
        a = int'(cmd[6:0]);
        exp_stb.delete();
        for (int k = 0; k < 17; k++) exp_rd[k] = 8'h00;
        for (int k = 0; k < ncomp; k++) begin
            if (cmd[7]) begin
                if (a < 4) begin
                    cfg_m[a] = wdata[k];
                    exp_stb.push_back(4'(1 << a));
                end
            end else if (a < 4) begin
                exp_rd[k+1] = cfg_m[a];
            end else if (a < 8) begin
                exp_rd[k+1] = status_m[a-4];
            end
            a = (a < 8) ? (a + 1) % 8 : 0;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (config_regs !== 32'h0) begin n_errors++; $display("FAIL reset_cfg: got %h expected %h", config_regs, 32'h0); end
        n_checks++;
        if (cfg_wr_stb !== 4'h0) begin n_errors++; $display("FAIL reset_stb: got %b expected %b", cfg_wr_stb, 4'h0); end
        n_checks++;
        if (sif.spi_miso !== 1'b0) begin n_errors++; $display("FAIL reset_miso: got %b expected 0", sif.spi_miso); end
        n_checks++;
        if (xfer_active !== 1'b0) begin n_errors++; $display("FAIL reset_xfer: got %b expected 0", xfer_active); end
    endtask

    task automatic test_write_mode0();
        wdata[0] = 8'hA5;
        wdata[1] = 8'h3C;
        spi_xfer(2'd0, 8'h80, 2, 0, 1'b0);
        model_xfer(8'h80, 2);
        n_checks++;
        if (config_regs[7:0] !== 8'hA5) begin n_errors++; $display("FAIL wr_cfg0: got %h expected a5", config_regs[7:0]); end
        n_checks++;
        if (config_regs[15:8] !== 8'h3C) begin n_errors++; $display("FAIL wr_cfg1: got %h expected 3c", config_regs[15:8]); end
        n_checks++;
        if (stb_log.size() !== 2) begin n_errors++; $display("FAIL wr_stb_count: got %0d expected 2", stb_log.size()); end
        else begin
            n_checks++;
            if (stb_log[0] !== 4'b0001) begin n_errors++; $display("FAIL wr_stb0: got %b expected 0001", stb_log[0]); end
            n_checks++;
            if (stb_log[1] !== 4'b0010) begin n_errors++; $display("FAIL wr_stb1: got %b expected 0010", stb_log[1]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rdata[k] !== 8'h00) begin n_errors++; $display("FAIL wr_miso_quiet[%0d]: got %h expected 00", k, rdata[k]); end
        end
    endtask

    task automatic test_read_modes();
        status_m[2] = 8'h55;
        set_status();
        for (int md = 1; md < 4; md++) begin
            spi_xfer(2'(md), 8'h06, 1, 0, 1'b0);
            model_xfer(8'h06, 1);
            n_checks++;
            if (rdata[1] !== 8'h55) begin n_errors++; $display("FAIL rd_mode%0d: got %h expected 55", md, rdata[1]); end
            n_checks++;
            if (rdata[0] !== 8'h00) begin n_errors++; $display("FAIL rd_cmd_quiet_mode%0d: got %h expected 00", md, rdata[0]); end
            n_checks++;
            if (stb_log.size() !== 0) begin n_errors++; $display("FAIL rd_no_stb_mode%0d: got %0d expected 0", md, stb_log.size()); end
        end
    endtask

    task automatic test_burst_wrap();
        status_m[3] = 8'h10;
        set_status();
        for (int md = 0; md < 4; md += 3) begin
            spi_xfer(2'(md), 8'h07, 3, 0, 1'b0);
            model_xfer(8'h07, 3);
            n_checks++;
            if (rdata[1] !== 8'h10) begin n_errors++; $display("FAIL wrap_w0_mode%0d: got %h expected 10", md, rdata[1]); end
            n_checks++;
            if (rdata[2] !== 8'hA5) begin n_errors++; $display("FAIL wrap_w1_mode%0d: got %h expected a5", md, rdata[2]); end
            n_checks++;
            if (rdata[3] !== 8'h3C) begin n_errors++; $display("FAIL wrap_w2_mode%0d: got %h expected 3c", md, rdata[3]); end
        end
    endtask

    task automatic test_discard();
        wdata[0] = 8'hFF;
        spi_xfer(2'd0, 8'h85, 1, 0, 1'b0);
        model_xfer(8'h85, 1);
        n_checks++;
        if (config_regs !== 32'h00003CA5) begin n_errors++; $display("FAIL status_wr_cfg: got %h expected 00003ca5", config_regs); end
        n_checks++;
        if (stb_log.size() !== 0) begin n_errors++; $display("FAIL status_wr_stb: got %0d expected 0", stb_log.size()); end
        spi_xfer(2'd1, 8'h7F, 2, 0, 1'b0);
        model_xfer(8'h7F, 2);
        n_checks++;
        if (rdata[1] !== 8'h00) begin n_errors++; $display("FAIL oor_read: got %h expected 00", rdata[1]); end
        n_checks++;
        if (rdata[2] !== exp_rd[2]) begin n_errors++; $display("FAIL oor_wrap: got %h expected %h", rdata[2], exp_rd[2]); end
    endtask

    task automatic test_abort();
        wdata[0] = 8'h5A;
        spi_xfer(2'd0, 8'h82, 1, 12, 1'b1);
        n_checks++;
        if (xfer_active !== 1'b1) begin n_errors++; $display("FAIL abort_active: got %b expected 1", xfer_active); end
        sif.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        model_xfer(8'h82, 0);
        n_checks++;
        if (xfer_active !== 1'b0) begin n_errors++; $display("FAIL abort_idle: got %b expected 0", xfer_active); end
        n_checks++;
        if (config_regs !== cfg_flat()) begin n_errors++; $display("FAIL abort_cfg: got %h expected %h", config_regs, cfg_flat()); end
        n_checks++;
        if (stb_log.size() !== 0) begin n_errors++; $display("FAIL abort_stb: got %0d expected 0", stb_log.size()); end
    endtask

    task automatic test_reset_mid_burst();
        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        wdata[2] = 8'h33;
        spi_xfer(2'd3, 8'h80, 3, 20, 1'b1);
        model_xfer(8'h80, 1);
        n_checks++;
        if (config_regs[7:0] !== 8'h11) begin n_errors++; $display("FAIL midrst_pre_cfg0: got %h expected 11", config_regs[7:0]); end
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (config_regs !== 32'h0) begin n_errors++; $display("FAIL midrst_cfg: got %h expected 0", config_regs); end
        n_checks++;
        if (cfg_wr_stb !== 4'h0) begin n_errors++; $display("FAIL midrst_stb: got %b expected 0", cfg_wr_stb); end
        n_checks++;
        if (sif.spi_miso !== 1'b0) begin n_errors++; $display("FAIL midrst_miso: got %b expected 0", sif.spi_miso); end
        n_checks++;
        if (xfer_active !== 1'b0) begin n_errors++; $display("FAIL midrst_xfer: got %b expected 0", xfer_active); end
        sif.spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) cfg_m[i] = 8'h00;
        wdata[0] = 8'h77;
        spi_xfer(2'd0, 8'h81, 1, 0, 1'b0);
        model_xfer(8'h81, 1);
        n_checks++;
        if (config_regs !== 32'h00007700) begin n_errors++; $display("FAIL postrst_cfg: got %h expected 00007700", config_regs); end
        n_checks++;
        if (stb_log.size() !== 1 || stb_log[0] !== 4'b0010) begin
            n_errors++; $display("FAIL postrst_stb: got %0d pulses expected one 0010", stb_log.size());
        end
    endtask

    task automatic test_ena();
        ena = 1'b0;
        wdata[0] = 8'h99;
        spi_xfer(2'd0, 8'h80, 1, 0, 1'b1);
        n_checks++;
        if (xfer_active !== 1'b0) begin n_errors++; $display("FAIL ena_xfer: got %b expected 0", xfer_active); end
        sif.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (config_regs !== cfg_flat()) begin n_errors++; $display("FAIL ena_cfg: got %h expected %h", config_regs, cfg_flat()); end
        n_checks++;
        if (stb_log.size() !== 0) begin n_errors++; $display("FAIL ena_stb: got %0d expected 0", stb_log.size()); end
    endtask

    task automatic test_random();
        logic [1:0] md;
        logic [7:0] cmd;
        int         nw;
        int         nb;
        int         ncomp;
        for (int t = 0; t < 24; t++) begin
            md = 2'($urandom_range(0, 3));
            cmd[7] = 1'($urandom_range(0, 1));
            cmd[6:0] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) wdata[k] = 8'($urandom);
            for (int k = 0; k < 4; k++) status_m[k] = 8'($urandom);
            set_status();
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * (nw + 1) - 1) : 0;
            ncomp = (nb == 0) ? nw : ((nb >= 8) ? (nb - 8) / 8 : 0);
            spi_xfer(md, cmd, nw, nb, 1'b0);
            model_xfer(cmd, ncomp);
            for (int k = 0; k <= ncomp; k++) begin
                n_checks++;
                if (rdata[k] !== exp_rd[k]) begin
                    n_errors++; $display("FAIL rnd%0d_miso[%0d] cmd=%h mode=%0d: got %h expected %h", t, k, cmd, md, rdata[k], exp_rd[k]);
                end
            end
            n_checks++;
            if (config_regs !== cfg_flat()) begin n_errors++; $display("FAIL rnd%0d_cfg cmd=%h: got %h expected %h", t, cmd, config_regs, cfg_flat()); end
            n_checks++;
            if (stb_log.size() !== exp_stb.size()) begin
                n_errors++; $display("FAIL rnd%0d_stb_count: got %0d expected %0d", t, stb_log.size(), exp_stb.size());
            end else begin
                for (int k = 0; k < exp_stb.size(); k++) begin
                    n_checks++;
                    if (stb_log[k] !== exp_stb[k]) begin n_errors++; $display("FAIL rnd%0d_stb[%0d]: got %b expected %b", t, k, stb_log[k], exp_stb[k]); end
                end
            end
            n_checks++;
            if (xfer_active !== 1'b0 || sif.spi_miso !== 1'b0) begin
                n_errors++; $display("FAIL rnd%0d_idle: got xfer=%b miso=%b expected 0 0", t, xfer_active, sif.spi_miso);
            end
        end
    endtask

    initial begin
        rstb         = 1'b0;
        ena          = 1'b1;
        sif.mode     = 2'd0;
        sif.spi_cs_n = 1'b1;
        sif.spi_clk  = 1'b0;
        sif.spi_mosi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_m[i]    = 8'h00;
            status_m[i] = 8'h00;
        end
        set_status();
        repeat (5) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_mode0();
        test_read_modes();
        test_burst_wrap();
        test_discard();
        test_abort();
        test_reset_mid_burst();
        test_ena();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_regbank_burst.md
# spi_regbank_burst

Parametrised SPI register-bank slave that succeeds the fixed two-config/two-status SPI wrapper in the TinyTapeout top level. It accepts already-synchronised SPI pins and supports all four CPOL/CPHA modes. Each transaction carries one command word followed by any number of data words, with the address auto-incrementing (burst access). It exposes a packed read/write config bank and a packed read-only status bank, and emits per-register write strobes for downstream logic.

## Interface
Parameters:
- NUM_CFG, 4, number of read/write config registers; addresses 0..NUM_CFG-1
- NUM_STATUS, 4, number of read-only status registers; addresses NUM_CFG..NUM_CFG+NUM_STATUS-1
- REG_WIDTH, 8, register and data-word width in bits
- ADDR_WIDTH, 7, address field width; command word is ADDR_WIDTH+1 bits
- CFG_RESET, 0, reset value applied to every config register (REG_WIDTH bits)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstb  in  1  reset; asynchronous assert, active-low
- ena  in  1  enable; when low, the block ignores all SPI edges and holds state
- mode  in  2  {cpol, cpha}, synchronised; sampled once per transaction, at cs_n fall
- spi_cs_n  in  1  chip select, active-low, synchronised
- spi_clk  in  1  SPI clock, synchronised
- spi_mosi  in  1  MOSI, synchronised
- spi_miso  out  1  MISO
- config_regs  out  NUM_CFG*REG_WIDTH  register i at [i*REG_WIDTH +: REG_WIDTH]
- cfg_wr_stb  out  NUM_CFG  one-cycle pulse per config register written
- status_regs  in  NUM_STATUS*REG_WIDTH  register j at [j*REG_WIDTH +: REG_WIDTH]
- xfer_active  out  1  high while a transaction is in the CMD or DATA state

## Operation
- Sample edge: leading edge of spi_clk when cpha=0, trailing edge when cpha=1. Leading edge means the level goes from cpol to !cpol.
- Shift edge: the opposite edge. MISO changes only on shift edges. All bits are MSB first.
- Command word:
  - bit ADDR_WIDTH is R/W, where 1 = write.
  - bits ADDR_WIDTH-1:0 are the start address.
- States:
  - IDLE → CMD on cs_n fall. This also latches mode and clears the bit counter.
  - CMD → DATA after ADDR_WIDTH+1 sample edges. The start address is latched at this point.
  - DATA loops per word of REG_WIDTH sample edges.
  - Any state → IDLE on cs_n high, regardless of bit count.
- Write word completes:
  - If the address is below NUM_CFG, the config register is updated and its cfg_wr_stb bit is pulsed.
  - Writes to status or out-of-range addresses are discarded and produce no strobe.
- Read word:
  - The source is selected at load time, as a snapshot: a config register, a status register, or 0 for an out-of-range address.
  - The word is loaded into the TX shifter on the first shift edge after the previous word (command or data) completes. Its MSB is driven on that edge.
  - For cpha=1, the first read word's MSB is driven on the leading edge of the first data bit.
- During write transactions and the command phase, MISO = 0.
- Address auto-increment after each completed word:
  - next = addr+1, or 0 if addr == NUM_CFG+NUM_STATUS-1.
  - An out-of-range address also goes to 0 after one word.
- A partial word at cs_n rise is discarded with no register change and no strobe. Words already completed remain committed.
- When cs_n is high, MISO = 0.
- ena low: edge detectors still track levels so no false edge occurs on re-enable. No state advances.

## Timing
- Reset values:
  - config_regs = CFG_RESET replicated.
  - cfg_wr_stb = 0, spi_miso = 0, xfer_active = 0.
  - State = IDLE, counters = 0.
- Edges are detected by comparing spi_clk against a one-cycle-delayed copy. An edge acts on the cycle after it appears on the synchronised input.
- Write commit: config_regs and cfg_wr_stb update on the same clk cycle, one cycle after the final sample edge is detected. The strobe lasts exactly one cycle.
- MISO updates one clk cycle after a shift edge is detected.
- The SPI clock must not exceed clk/8 (2-stage external synchroniser plus edge-detect latency).
- If cs_n rises on the same cycle as a word-completing sample edge, cs_n wins: the word is discarded.
- rstb asserted mid-transaction forces IDLE immediately, with no commit.

## Structure
- Package spi_regbank_pkg holds:
  - the state enum {IDLE, CMD, DATA}
  - the R/W bit position
  - the mode-to-edge mapping function
- One sub-module, spi_edge_det:
  - inputs: clk, rstb, spi_clk, latched mode
  - outputs: sample_stb and shift_stb
- The top block owns the FSM, RX/TX shifters, address counter and register bank.

## Test plan
- Mode 0, write cmd 0x80, then data 0xA5, 0x3C → cfg0=0xA5 and cfg1=0x3C; cfg_wr_stb pulses 0001 then 0010.
- Modes 1, 2 and 3: status2=0x55, read cmd 0x06 → MISO byte 0x55. Repeat all three modes.
- Burst wrap: read cmd 0x07 with three data words, status3=0x10, cfg0=0xA5 → 0x10, 0xA5, then cfg1.
- Write cmd 0x85 with 0xFF → status unaffected, no strobe. Read cmd 0x7F → 0x00.
- Abort: cs_n rises after 4 data bits of a write to cfg2 → cfg2 unchanged, no strobe, xfer_active falls.
- rstb pulsed mid-burst → all outputs at reset values. The next full transaction completes normally.
